// File: rtl/vocoder_band_mixer.sv
// vocoder_band_mixer
// Per-sample band mixer for a channel vocoder. Each band's carrier is
// weighted by its modulator envelope, and negative envelopes count as zero.
// The weighted bands are summed with one time-shared multiplier, one band per
// cycle. The sum is then rescaled by an arithmetic right shift and narrowed
// to a single mono output sample.
//
// Build option: define VOCODER_MIXER_SAT_EN to clamp the rescaled sum to the
// signed WIDTH-bit range. Without it, the low WIDTH bits are kept and
// out-of-range results wrap.
module vocoder_band_mixer #(
    parameter int WIDTH     = 24,
    parameter int NUM_BANDS = 16,
    parameter int SHIFT     = 20
) (
    input  logic                       clk_in,
    input  logic                       rst_in,
    input  logic                       sample_valid_in,
    input  logic [NUM_BANDS*WIDTH-1:0] carrier_in,
    input  logic [NUM_BANDS*WIDTH-1:0] envelope_in,
    output logic [WIDTH-1:0]           sample_out,
    output logic                       sample_valid_out,
    output logic                       busy_out,
    output logic                       overrun_out
);

    localparam int IDX_W = $clog2(NUM_BANDS);
    localparam int ACC_W = 2*WIDTH + IDX_W;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_BANDS-1);

`ifdef VOCODER_MIXER_SAT_EN
    localparam logic signed [ACC_W-1:0] SAT_MAX =
        {{(ACC_W-WIDTH+1){1'b0}}, {(WIDTH-1){1'b1}}};
    localparam logic signed [ACC_W-1:0] SAT_MIN =
        {{(ACC_W-WIDTH+1){1'b1}}, {(WIDTH-1){1'b0}}};
`endif

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_MAC  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    state_t                     r_state;
    logic [IDX_W-1:0]           r_idx;
    logic signed [ACC_W-1:0]    r_acc;
    logic [NUM_BANDS*WIDTH-1:0] r_carrier;
    logic [NUM_BANDS*WIDTH-1:0] r_envelope;
    logic [WIDTH-1:0]           r_sample;
    logic                       r_valid;
    logic                       r_busy;
    logic                       r_overrun;

    logic signed [WIDTH-1:0]    w_carrier;
    logic signed [WIDTH-1:0]    w_env;
    logic signed [WIDTH-1:0]    w_env_pos;
    logic signed [2*WIDTH-1:0]  w_prod;
    logic signed [ACC_W-1:0]    w_prod_ext;

    // Rescale the accumulated sum and narrow it to the output width.
    function automatic logic [WIDTH-1:0] f_narrow(input logic signed [ACC_W-1:0] acc);
        logic signed [ACC_W-1:0] scaled;
        scaled = acc >>> SHIFT;
`ifdef VOCODER_MIXER_SAT_EN
        if (scaled > SAT_MAX) begin
            return SAT_MAX[WIDTH-1:0];
        end else if (scaled < SAT_MIN) begin
            return SAT_MIN[WIDTH-1:0];
        end else begin
            return scaled[WIDTH-1:0];
        end
`else
        return scaled[WIDTH-1:0];
`endif
    endfunction

    // Select the current band, clamp a negative envelope to zero, and form the product.
    always_comb begin
        w_carrier = r_carrier[r_idx*WIDTH +: WIDTH];
        w_env     = r_envelope[r_idx*WIDTH +: WIDTH];
        if (w_env[WIDTH-1]) begin
            w_env_pos = {WIDTH{1'b0}};
        end else begin
            w_env_pos = w_env;
        end
        w_prod     = w_carrier * w_env_pos;
        w_prod_ext = {{(ACC_W-2*WIDTH){w_prod[2*WIDTH-1]}}, w_prod};
    end

    // Control FSM, multiply-accumulate datapath and registered outputs.
    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            r_state    <= ST_IDLE;
            r_idx      <= {IDX_W{1'b0}};
            r_acc      <= {ACC_W{1'b0}};
            r_carrier  <= {(NUM_BANDS*WIDTH){1'b0}};
            r_envelope <= {(NUM_BANDS*WIDTH){1'b0}};
            r_sample   <= {WIDTH{1'b0}};
            r_valid    <= 1'b0;
            r_busy     <= 1'b0;
            r_overrun  <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    r_valid <= 1'b0;
                    if (sample_valid_in) begin
                        r_carrier  <= carrier_in;
                        r_envelope <= envelope_in;
                        r_acc      <= {ACC_W{1'b0}};
                        r_idx      <= {IDX_W{1'b0}};
                        r_busy     <= 1'b1;
                        r_state    <= ST_MAC;
                    end else begin
                        r_busy <= 1'b0;
                    end
                end
                ST_MAC: begin
                    r_valid <= 1'b0;
                    r_busy  <= 1'b1;
                    r_acc   <= r_acc + w_prod_ext;
                    if (sample_valid_in) begin
                        r_overrun <= 1'b1;
                    end else begin
                        r_overrun <= r_overrun;
                    end
                    if (r_idx == LAST_IDX) begin
                        r_idx   <= {IDX_W{1'b0}};
                        r_state <= ST_DONE;
                    end else begin
                        r_idx <= r_idx + {{(IDX_W-1){1'b0}}, 1'b1};
                    end
                end
                ST_DONE: begin
                    r_sample <= f_narrow(r_acc);
                    r_valid  <= 1'b1;
                    if (sample_valid_in) begin
                        // A new sample set in DONE starts immediately, so throughput is back-to-back.
                        r_carrier  <= carrier_in;
                        r_envelope <= envelope_in;
                        r_acc      <= {ACC_W{1'b0}};
                        r_idx      <= {IDX_W{1'b0}};
                        r_busy     <= 1'b1;
                        r_state    <= ST_MAC;
                    end else begin
                        r_busy  <= 1'b0;
                        r_state <= ST_IDLE;
                    end
                end
                default: begin
                    r_state <= ST_IDLE;
                    r_valid <= 1'b0;
                    r_busy  <= 1'b0;
                end
            endcase
        end
    end

    assign sample_out       = r_sample;
    assign sample_valid_out = r_valid;
    assign busy_out         = r_busy;
    assign overrun_out      = r_overrun;

endmodule

// File: tb/tb_vocoder_band_mixer.sv
// Directed testbench for vocoder_band_mixer with WIDTH=24, NUM_BANDS=4, SHIFT=20.
module tb_vocoder_band_mixer;

    localparam int W  = 24;
    localparam int NB = 4;

    logic            clk_in = 1'b0;
    logic            rst_in = 1'b1;
    logic            sample_valid_in = 1'b0;
    logic [NB*W-1:0] carrier_in = '0;
    logic [NB*W-1:0] envelope_in = '0;
    logic [W-1:0]    sample_out;
    logic            sample_valid_out;
    logic            busy_out;
    logic            overrun_out;

    int errors = 0;
    int checks = 0;

    vocoder_band_mixer #(.WIDTH(W), .NUM_BANDS(NB), .SHIFT(20)) dut (
        .clk_in           (clk_in),
        .rst_in           (rst_in),
        .sample_valid_in  (sample_valid_in),
        .carrier_in       (carrier_in),
        .envelope_in      (envelope_in),
        .sample_out       (sample_out),
        .sample_valid_out (sample_valid_out),
        .busy_out         (busy_out),
        .overrun_out      (overrun_out)
    );

    always #5 clk_in = ~clk_in;

    task automatic check_val(input string tag, input longint obs, input longint exp);
        checks++;
        if (obs != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    function automatic logic [NB*W-1:0] pack4(input logic signed [W-1:0] a, input logic signed [W-1:0] b,
                                              input logic signed [W-1:0] c, input logic signed [W-1:0] d);
        return {d, c, b, a};
    endfunction

    // Capture one sample set, then check the result value, latency, busy duration and the single-cycle valid pulse.
    task automatic run_sample(input string tag, input logic [NB*W-1:0] car, input logic [NB*W-1:0] env,
                              input longint exp);
        int lat;
        int busy_cnt;
        @(negedge clk_in);
        carrier_in      = car;
        envelope_in     = env;
        sample_valid_in = 1'b1;
        @(posedge clk_in);
        #1;
        sample_valid_in = 1'b0;
        lat      = 0;
        busy_cnt = 0;
        while (!sample_valid_out && lat < 20) begin
            if (busy_out) busy_cnt++;
            @(posedge clk_in);
            #1;
            lat++;
        end
        check_val({tag, " latency"}, lat, 5);
        check_val({tag, " busy cycles"}, busy_cnt, 5);
        check_val({tag, " busy low at valid"}, busy_out, 0);
        check_val({tag, " sample"}, $signed(sample_out), exp);
        @(posedge clk_in);
        #1;
        check_val({tag, " valid one cycle"}, sample_valid_out, 0);
        check_val({tag, " sample held"}, $signed(sample_out), exp);
    endtask

    task automatic do_reset();
        @(negedge clk_in);
        rst_in = 1'b1;
        @(negedge clk_in);
        rst_in = 1'b0;
    endtask

    logic [NB*W-1:0] c1000;
    logic [NB*W-1:0] cmax;
    logic [NB*W-1:0] cmin;
    logic [NB*W-1:0] eunity;
    logic [NB*W-1:0] emax;
    int              lat;
    int              seen;

    initial begin
        c1000  = pack4(24'sd1000, 24'sd1000, 24'sd1000, 24'sd1000);
        cmax   = pack4(24'sd8388607, 24'sd8388607, 24'sd8388607, 24'sd8388607);
        cmin   = pack4(-24'sd8388608, -24'sd8388608, -24'sd8388608, -24'sd8388608);
        eunity = pack4(24'sd1048576, 24'sd1048576, 24'sd1048576, 24'sd1048576);
        emax   = cmax;

        repeat (3) @(posedge clk_in);
        #1;
        check_val("reset sample_out", sample_out, 0);
        check_val("reset valid", sample_valid_out, 0);
        check_val("reset busy", busy_out, 0);
        check_val("reset overrun", overrun_out, 0);
        @(negedge clk_in);
        rst_in = 1'b0;

        run_sample("unity", c1000, eunity, 4000);
        run_sample("neg clamp", c1000,
                   pack4(24'sd1048576, -24'sd500, 24'sd1048576, -24'sd8388608), 2000);
`ifdef VOCODER_MIXER_SAT_EN
        run_sample("sat pos", cmax, emax, 8388607);
        run_sample("sat neg", cmin, emax, -8388608);
`else
        run_sample("wrap pos", cmax, emax, -64);
        run_sample("wrap neg", cmin, emax, 32);
`endif
        check_val("no overrun yet", overrun_out, 0);

        // A second valid two cycles into MAC is dropped and flags overrun.
        @(negedge clk_in);
        carrier_in = c1000; envelope_in = eunity; sample_valid_in = 1'b1;
        @(posedge clk_in); #1;
        sample_valid_in = 1'b0;
        @(posedge clk_in); #1;
        carrier_in = cmax; envelope_in = emax; sample_valid_in = 1'b1;
        @(posedge clk_in); #1;
        sample_valid_in = 1'b0;
        lat = 2;
        while (!sample_valid_out && lat < 20) begin
            @(posedge clk_in); #1;
            lat++;
        end
        check_val("overrun latency", lat, 5);
        check_val("overrun first result", $signed(sample_out), 4000);
        check_val("overrun sticky", overrun_out, 1);
        repeat (3) @(posedge clk_in);
        #1;
        check_val("overrun still set", overrun_out, 1);
        check_val("overrun busy idle", busy_out, 0);

        // A valid presented during DONE is accepted back-to-back.
        do_reset();
        check_val("overrun cleared", overrun_out, 0);
        @(negedge clk_in);
        carrier_in = c1000; envelope_in = eunity; sample_valid_in = 1'b1;
        @(posedge clk_in); #1;
        sample_valid_in = 1'b0;
        repeat (4) @(posedge clk_in);
        #1;
        carrier_in = c1000;
        envelope_in = pack4(24'sd1048576, -24'sd500, 24'sd1048576, -24'sd8388608);
        sample_valid_in = 1'b1;
        @(posedge clk_in); #1;
        sample_valid_in = 1'b0;
        carrier_in = cmax; envelope_in = emax;
        check_val("b2b first valid", sample_valid_out, 1);
        check_val("b2b first result", $signed(sample_out), 4000);
        check_val("b2b busy kept", busy_out, 1);
        lat = 0;
        do begin
            @(posedge clk_in); #1;
            lat++;
        end while (!sample_valid_out && lat < 20);
        check_val("b2b second latency", lat, 5);
        check_val("b2b second result", $signed(sample_out), 2000);
        check_val("b2b overrun", overrun_out, 0);

        // Reset sampled on edge 2 of a computation discards it.
        repeat (2) @(posedge clk_in);
        @(negedge clk_in);
        carrier_in = c1000; envelope_in = eunity; sample_valid_in = 1'b1;
        @(posedge clk_in); #1;
        sample_valid_in = 1'b0;
        @(posedge clk_in); #1;
        rst_in = 1'b1;
        @(posedge clk_in); #1;
        rst_in = 1'b0;
        check_val("midrst sample", sample_out, 0);
        check_val("midrst valid", sample_valid_out, 0);
        check_val("midrst busy", busy_out, 0);
        check_val("midrst overrun", overrun_out, 0);
        seen = 0;
        repeat (10) begin
            @(posedge clk_in); #1;
            if (sample_valid_out) seen++;
        end
        check_val("midrst no pulse", seen, 0);

        // Valid coincident with reset is ignored.
        @(negedge clk_in);
        rst_in = 1'b1; sample_valid_in = 1'b1;
        @(posedge clk_in); #1;
        rst_in = 1'b0; sample_valid_in = 1'b0;
        @(posedge clk_in); #1;
        check_val("rst+valid busy", busy_out, 0);

        run_sample("post reset", c1000, eunity, 4000);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
